// File: rtl/cpu_wb_pkg.sv
// Shared types and defaults for the writeback datapath blocks.
package cpu_wb_pkg;

    localparam int unsigned DEFAULT_DATA_WID = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/cpu_wb_seq_multiplier_if.sv
// Operand and product handshakes of the sequential multiplier.
interface cpu_wb_seq_multiplier_if
    import cpu_wb_pkg::*;
#(
    parameter int unsigned DATA_WID = DEFAULT_DATA_WID
);

    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WID-1:0]     in_a;
    logic [DATA_WID-1:0]     in_b;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*DATA_WID-1:0]   out_product;
    logic                    busy;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_product, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_product, busy
    );

endinterface

// File: rtl/cpu_wb_cla_adder.sv
// Combinational carry-lookahead adder built from 4-bit lookahead groups.
module cpu_wb_cla_adder
    import cpu_wb_pkg::*;
#(
    parameter int unsigned DATA_WID = DEFAULT_DATA_WID
) (
    input  logic [DATA_WID-1:0] in1,
    input  logic [DATA_WID-1:0] in2,
    input  logic                carry_in,
    output logic [DATA_WID-1:0] sum,
    output logic                carry_out
);

    localparam int unsigned GRP_WID = 4;
    localparam int unsigned NUM_GRP = (DATA_WID + GRP_WID - 1) / GRP_WID;
    localparam int unsigned PAD_WID = NUM_GRP * GRP_WID;

    logic [PAD_WID-1:0] gen;
    logic [PAD_WID-1:0] prop;
    logic [PAD_WID:0]   carry_vec;

    // Padding bits have gen=prop=0, so they never disturb the real carries.
    assign gen  = PAD_WID'(in1 & in2);
    assign prop = PAD_WID'(in1 ^ in2);

    // Full lookahead inside each group; group carries chain between groups.
    always_comb begin
        carry_vec    = '0;
        carry_vec[0] = carry_in;
        for (int unsigned g = 0; g < NUM_GRP; g++) begin
            carry_vec[GRP_WID*g + 1] = gen[GRP_WID*g]
                                     | (prop[GRP_WID*g] & carry_vec[GRP_WID*g]);
            carry_vec[GRP_WID*g + 2] = gen[GRP_WID*g + 1]
                                     | (prop[GRP_WID*g + 1] & gen[GRP_WID*g])
                                     | (prop[GRP_WID*g + 1] & prop[GRP_WID*g]
                                        & carry_vec[GRP_WID*g]);
            carry_vec[GRP_WID*g + 3] = gen[GRP_WID*g + 2]
                                     | (prop[GRP_WID*g + 2] & gen[GRP_WID*g + 1])
                                     | (prop[GRP_WID*g + 2] & prop[GRP_WID*g + 1]
                                        & gen[GRP_WID*g])
                                     | (prop[GRP_WID*g + 2] & prop[GRP_WID*g + 1]
                                        & prop[GRP_WID*g] & carry_vec[GRP_WID*g]);
            carry_vec[GRP_WID*g + 4] = gen[GRP_WID*g + 3]
                                     | (prop[GRP_WID*g + 3] & gen[GRP_WID*g + 2])
                                     | (prop[GRP_WID*g + 3] & prop[GRP_WID*g + 2]
                                        & gen[GRP_WID*g + 1])
                                     | (prop[GRP_WID*g + 3] & prop[GRP_WID*g + 2]
                                        & prop[GRP_WID*g + 1] & gen[GRP_WID*g])
                                     | (prop[GRP_WID*g + 3] & prop[GRP_WID*g + 2]
                                        & prop[GRP_WID*g + 1] & prop[GRP_WID*g]
                                        & carry_vec[GRP_WID*g]);
        end
    end

    assign sum       = in1 ^ in2 ^ carry_vec[DATA_WID-1:0];
    assign carry_out = carry_vec[DATA_WID];

endmodule

// File: rtl/cpu_wb_seq_multiplier.sv
// Unsigned radix-2 shift-and-add multiplier, one multiplier bit per cycle,
// with valid/ready handshakes on the operand and product sides.
module cpu_wb_seq_multiplier
    import cpu_wb_pkg::*;
#(
    parameter int unsigned DATA_WID = DEFAULT_DATA_WID
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cpu_wb_seq_multiplier_if.slave  bus
);

    localparam int unsigned CNT_WID  = $clog2(DATA_WID);
    localparam int unsigned PROD_WID = 2 * DATA_WID;
    localparam logic [CNT_WID-1:0] LAST_ITER = CNT_WID'(DATA_WID - 1);

    mul_state_t            state_q;
    mul_state_t            next_state;
    logic [CNT_WID-1:0]    counter_q;
    logic [DATA_WID-1:0]   acc_hi_q;
    logic [DATA_WID-1:0]   mul_lo_q;
    logic [DATA_WID-1:0]   mcand_q;
    logic                  out_valid_q;
    logic [PROD_WID-1:0]   out_product_q;
    logic                  in_ready_q;
    logic                  busy_q;

    logic [DATA_WID-1:0]   addend;
    logic [DATA_WID-1:0]   add_sum;
    logic                  add_carry;
    logic [PROD_WID-1:0]   shifted;
    logic                  last_iter;

    assign addend    = mul_lo_q[0] ? mcand_q : '0;
    assign last_iter = (counter_q == LAST_ITER);

    cpu_wb_cla_adder #(
        .DATA_WID (DATA_WID)
    ) u_adder (
        .in1       (acc_hi_q),
        .in2       (addend),
        .carry_in  (1'b0),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // {carry, sum, mul_lo} shifted right by one; the dropped LSB is the consumed multiplier bit.
    assign shifted = {add_carry, add_sum, mul_lo_q[DATA_WID-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) next_state = CALC;
            CALC: if (last_iter) next_state = DONE;
            DONE: if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q     <= '0;
            acc_hi_q      <= '0;
            mul_lo_q      <= '0;
            mcand_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            in_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            in_ready_q <= (next_state == IDLE);
            busy_q     <= (next_state != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q   <= bus.in_a;
                        mul_lo_q  <= bus.in_b;
                        acc_hi_q  <= '0;
                        counter_q <= '0;
                    end
                end
                CALC: begin
                    acc_hi_q  <= shifted[PROD_WID-1:DATA_WID];
                    mul_lo_q  <= shifted[DATA_WID-1:0];
                    counter_q <= counter_q + CNT_WID'(1);
                    if (last_iter) begin
                        out_product_q <= shifted;
                        out_valid_q   <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;

endmodule

// File: tb/tb_cpu_wb_seq_multiplier.sv
// Bench for cpu_wb_seq_multiplier: directed corner cases plus random traffic
// against a transaction-level model (queue of a*b with due cycles).
module tb_cpu_wb_seq_multiplier;

    localparam int unsigned W = 32;
    localparam int unsigned N_RAND = 1000;

    logic clk;
    logic rst_n;

    cpu_wb_seq_multiplier_if #(.DATA_WID(W)) bus ();

    cpu_wb_seq_multiplier #(.DATA_WID(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
        int          due;
        bit          pin_en;
        logic [63:0] pin_prod;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          m_qsize = 0;
    int          tmo = 0;
    bit          model_on = 1'b0;
    bit          m_ov = 1'b0;
    bit          done = 1'b0;
    bit          dut_ov_prev = 1'b0;
    logic [63:0] last_prod = '0;
    bit          pin_en = 1'b0;
    logic [63:0] pin_prod = '0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: at most one product in flight; it appears W edges after the accept
    // edge and leaves on the edge where it is valid and out_ready is high.
    always @(negedge clk) begin
        bit          exp_ov;
        bit          idle_now;
        logic [63:0] exp_p;
        exp_t        e;
        cyc++;
        exp_ov = 1'b0;
        if (model_on) begin
            exp_ov = (q.size() != 0) && (cyc >= q[0].due);
            check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            check("in_ready", 64'(bus.in_ready), 64'(q.size() == 0));
            check("busy", 64'(bus.busy), 64'(q.size() != 0));
            exp_p = exp_ov ? q[0].prod : last_prod;
            check("out_product", bus.out_product, exp_p);
            if (bus.out_valid === 1'b1 && !dut_ov_prev && q.size() != 0 && q[0].pin_en) begin
                check("pinned_product", bus.out_product, q[0].pin_prod);
                check("pinned_latency", 64'(cyc - q[0].acc_cyc), 64'd32);
            end
        end
        dut_ov_prev = (bus.out_valid === 1'b1);

        if (rst_n !== 1'b1) begin
            q.delete();
            last_prod = '0;
            model_on  = 1'b1;
        end else if (model_on) begin
            idle_now = (q.size() == 0);
            if (exp_ov && bus.out_ready) begin
                last_prod = q[0].prod;
                void'(q.pop_front());
            end
            if (idle_now && bus.in_valid) begin
                e.prod     = 64'(bus.in_a) * 64'(bus.in_b);
                e.acc_cyc  = cyc + 1;
                e.due      = cyc + 1 + int'(W);
                e.pin_en   = pin_en;
                e.pin_prod = pin_prod;
                q.push_back(e);
                acc_cnt++;
            end
        end
        m_qsize = q.size();
        m_ov    = (q.size() != 0) && (cyc >= q[0].due);

        if (done) begin
            check("watchdog_timeouts", 64'(tmo), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
        if (cyc > 95000) begin
            $display("FAIL global_timeout: got cycle %0d, want completion", cyc);
            $fatal(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_op();
        unique case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // Present one operand pair and hold it until the model registers the accept.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit pe, input logic [63:0] pp);
        int seen;
        seen         = acc_cnt;
        pin_en       = pe;
        pin_prod     = pp;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (acc_cnt != seen) break;
        end
        if (acc_cnt == seen) tmo++;
        bus.in_valid = 1'b0;
        pin_en       = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (m_qsize == 0) return;
            tick();
        end
        tmo++;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 500; i++) begin
            if (m_ov) return;
            tick();
        end
        tmo++;
    endtask

    initial begin
        int sent;
        int seen;
        int c;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        bus.out_ready = 1'b1;
        send(32'd3, 32'd5, 1'b1, 64'd15);
        wait_idle();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        wait_idle();
        send(32'h1234_5678, 32'h0, 1'b1, 64'h0);
        wait_idle();

        // Backpressure: product held, new operands ignored while busy.
        bus.out_ready = 1'b0;
        send(32'd7, 32'd9, 1'b1, 64'd63);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin
                bus.in_a     = 32'd1;
                bus.in_b     = 32'd1;
                bus.in_valid = 1'b1;
            end
            if (i == 6) bus.in_valid = 1'b0;
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset on the fifth CALC edge abandons the operation.
        send(32'd11, 32'd13, 1'b0, 64'h0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(32'd6, 32'd7, 1'b1, 64'd42);
        wait_idle();

        // Random operands with random in_valid gaps and out_ready stalls.
        sent = 0;
        seen = acc_cnt;
        c    = 0;
        while (c < 80000 && (sent < int'(N_RAND) || m_qsize != 0)) begin
            bus.out_ready = ($urandom_range(3) != 0);
            if (bus.in_valid && acc_cnt != seen) begin
                bus.in_valid = 1'b0;
                sent++;
                seen     = acc_cnt;
                bus.in_a = $urandom;
                bus.in_b = $urandom;
            end
            if (!bus.in_valid && sent < int'(N_RAND) && $urandom_range(2) == 0) begin
                bus.in_a     = rand_op();
                bus.in_b     = rand_op();
                bus.in_valid = 1'b1;
            end
            tick();
            c++;
        end
        if (sent < int'(N_RAND) || m_qsize != 0) tmo++;
        bus.in_valid = 1'b0;
        done = 1'b1;
    end

endmodule

// File: doc/cpu_wb_seq_multiplier.md
Name: cpu_wb_seq_multiplier

Overview:
Unsigned radix-2 shift-and-add multiplier for the writeback datapath. It accepts operand pairs over a valid/ready handshake and iterates one bit per cycle. Each iteration drives the team's combinational cpu_wb_cla_adder and consumes its sum and carry_out. The full 2*DATA_WID product is returned over a second valid/ready handshake.

Parameters:
DATA_WID, 32, operand width in bits; legal range >= 2; also passed to the adder instance.

Ports:
clk  input  1  single clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
in_a  input  DATA_WID  multiplicand, unsigned
in_b  input  DATA_WID  multiplier, unsigned
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_product  output  2*DATA_WID  unsigned product in_a*in_b
busy  output  1  high in CALC or DONE

Behaviour:
- Reset: one clock, synchronous, active-low. rst_n sampled low at a rising edge gives:
  - state=IDLE, counter=0, acc_hi=0, mul_lo=0, mcand=0
  - out_valid=0, out_product=0, busy=0
  - in_ready=1 from the first cycle after the reset edge.
- Reset mid-operation (CALC or DONE): the operation is abandoned and the product is discarded. No out_valid is produced for it.
- States: IDLE, CALC, DONE.
- in_ready = (state==IDLE). No new operands are accepted while busy.
- IDLE -> CALC on an edge with in_valid & in_ready. Loads:
  - mcand=in_a, mul_lo=in_b, acc_hi=0, counter=0.
- CALC, each edge:
  - Adder inputs: in1=acc_hi, in2 = mul_lo[0] ? mcand : 0, carry_in=0.
  - {acc_hi, mul_lo} <= {carry_out, sum, mul_lo} >> 1 (a (2*DATA_WID+1)-bit right shift; the LSB is dropped).
  - counter increments.
  - On the edge where counter==DATA_WID-1: go to DONE, out_product <= the shifted result, out_valid <= 1.
- Latency: out_valid is first high in the cycle after the DATA_WID-th edge following the accept edge. With DATA_WID=32, that is 32 edges after acceptance.
- DONE:
  - out_valid=1; out_product held stable while out_ready=0.
  - On an edge with out_valid & out_ready: go to IDLE, out_valid <= 0.
  - out_product keeps its last value in IDLE; it is meaningful only while out_valid=1.
- Throughput: one product per DATA_WID+2 cycles when out_ready is held high.
- in_valid asserted while in_ready=0 is ignored. The producer must hold operands until accepted.
- in_a/in_b changing after the accept edge does not affect the result.
- Width rules:
  - All arithmetic is unsigned and no overflow is possible.
  - Counter width is $clog2(DATA_WID); wrap-around is impossible because the exit is at DATA_WID-1.
- Zero operand: still takes the full DATA_WID iterations; there is no early-exit.

Decomposition:
- Shared package cpu_wb_pkg:
  - typedef enum for mul_state_t {IDLE, CALC, DONE}
  - localparam default for DATA_WID.
- One sub-module: cpu_wb_cla_adder, instantiated once with DATA_WID, carry_in tied to 0.
- Datapath registers, FSM and handshake logic stay in cpu_wb_seq_multiplier.

Test Plan:
- DATA_WID=32; in_a=3, in_b=5, out_ready=1 -> out_product=15, with out_valid exactly 32 edges after the accept edge.
- in_a=0xFFFFFFFF, in_b=0xFFFFFFFF -> out_product=0xFFFFFFFE_00000001. Exercises adder carry_out capture on every iteration.
- in_a=0x12345678, in_b=0 -> out_product=0 after the full 32 cycles; busy high throughout CALC.
- Backpressure: product 7*9 with out_ready=0 for 10 cycles:
  - out_valid stays 1, out_product stays 63, in_ready stays 0, and a new in_valid is ignored.
  - Raising out_ready gives IDLE on the next cycle.
- Reset mid-CALC at iteration 5:
  - Next cycle: out_valid=0, in_ready=1, busy=0, out_product=0.
  - A following 6*7 returns 42 with correct latency.
- 1000 random operand pairs with random in_valid/out_ready gaps -> every product matches a golden a*b, in order, with none lost or duplicated.
